pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight register writers past decode and derives
// forwarding selects, interlocks, branch flush, memory freeze and the halt drain sequence.
module pipeline_hazard_ctrl #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned FWD_EN = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        id_valid,
    input  logic [REG_W-1:0]            id_rs,
    input  logic [REG_W-1:0]            id_rt,
    input  logic                        id_uses_rs,
    input  logic                        id_uses_rt,
    input  logic                        id_wen,
    input  logic [REG_W-1:0]            id_wsel,
    input  logic                        id_is_load,
    input  logic                        id_halt,
    input  logic                        branch_taken,
    input  logic                        mem_wait,
    output logic                        stall_if,
    output logic                        stall_id,
    output logic                        flush_if,
    output logic                        freeze,
    output logic [$clog2(STAGES+1)-1:0] fwd_a_sel,
    output logic [$clog2(STAGES+1)-1:0] fwd_b_sel,
    output logic                        halt,
    output logic                        busy
);
    localparam int unsigned SEL_W = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Entry k describes the instruction k stages past ID.
    logic [STAGES:1]  sb_valid;
    logic [STAGES:1]  sb_wen;
    logic [STAGES:1]  sb_load;
    logic [REG_W-1:0] sb_wsel [1:STAGES];

    logic [STAGES:1]  match_a;
    logic [STAGES:1]  match_b;
    logic             hazard;
    logic             ins_take;
    logic             ins_valid;
    logic             ins_wen;
    logic             ins_load;
    logic             halt_accept;

    // Per-entry source matches against the decode-stage operands.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= STAGES; k++) begin
            match_a[k] = sb_valid[k] & sb_wen[k] & (sb_wsel[k] == id_rs)
                       & (id_rs != '0) & id_uses_rs;
            match_b[k] = sb_valid[k] & sb_wen[k] & (sb_wsel[k] == id_rt)
                       & (id_rt != '0) & id_uses_rt;
        end
    end

    // Youngest matching entry wins: scan oldest to youngest so the last hit sticks.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        if (FWD_EN != 0) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (match_a[k]) begin
                    fwd_a_sel = SEL_W'(k);
                end
                if (match_b[k]) begin
                    fwd_b_sel = SEL_W'(k);
                end
            end
        end
    end

    // Without forwarding, wait until the producer reaches the write-through stage.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = sb_load[1] & (match_a[1] | match_b[1]);
        end else begin
            hazard = |(match_a[STAGES-1:1] | match_b[STAGES-1:1]);
        end
    end

    always_comb begin
        ins_take    = (state == ST_RUN) & ~branch_taken & ~stall_id;
        ins_valid   = ins_take & id_valid;
        ins_wen     = ins_valid & id_wen & ~id_halt;
        ins_load    = ins_valid & id_is_load & ~id_halt;
        halt_accept = (state == ST_RUN) & id_valid & id_halt & ~stall_id
                    & ~branch_taken & ~mem_wait;
        busy        = |sb_valid;
    end

    // Scoreboard shift; a rejected or discarded decode slot enters as a bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_valid <= '0;
            sb_wen   <= '0;
            sb_load  <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                sb_wsel[k] <= '0;
            end
        end else if (!mem_wait) begin
            sb_valid <= {sb_valid[STAGES-1:1], ins_valid};
            sb_wen   <= {sb_wen[STAGES-1:1], ins_wen};
            sb_load  <= {sb_load[STAGES-1:1], ins_load};
            for (int k = STAGES; k >= 2; k--) begin
                sb_wsel[k] <= sb_wsel[k-1];
            end
            sb_wsel[1] <= id_wsel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!mem_wait) begin
            unique case (state)
                ST_RUN: begin
                    if (halt_accept) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_RUN;
            endcase
        end
    end

    // Freeze outranks branch flush, which outranks the data interlock.
    always_comb begin
        freeze   = mem_wait;
        stall_id = hazard & ~branch_taken;
        stall_if = mem_wait | stall_id;
        flush_if = 1'b0;
        halt     = 1'b0;
        unique case (state)
            ST_RUN: begin
                flush_if = branch_taken & ~mem_wait;
            end
            ST_DRAIN: begin
                stall_if = 1'b1;
                flush_if = ~mem_wait;
            end
            ST_HALTED: begin
                stall_if = 1'b1;
                halt     = 1'b1;
            end
            default: begin
                stall_if = mem_wait | stall_id;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a forwarding instance and a stall-only instance share the
// decode-side stimulus; per-cycle expected outputs flow through a queue and are compared.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned STAGES = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned FW     = $clog2(STAGES + 1);
    localparam int unsigned OW     = 6 + 2 * FW;

    typedef struct {
        logic             rst;
        logic             v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             urs;
        logic             urt;
        logic             wen;
        logic [REG_W-1:0] ws;
        logic             ld;
        logic             hl;
        logic             br;
        logic             mw;
    } stim_t;

    typedef struct {
        string         tag;
        logic [OW-1:0] v;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_wen;
    logic [REG_W-1:0] id_wsel;
    logic             id_is_load;
    logic             id_halt;
    logic             branch_taken;
    logic             mem_wait;

    logic          u0_stall_if, u0_stall_id, u0_flush_if, u0_freeze, u0_halt, u0_busy;
    logic [FW-1:0] u0_fwd_a_sel, u0_fwd_b_sel;
    logic          u1_stall_if, u1_stall_id, u1_flush_if, u1_freeze, u1_halt, u1_busy;
    logic [FW-1:0] u1_fwd_a_sel, u1_fwd_b_sel;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .FWD_EN(1)) u0 (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_wsel(id_wsel),
        .id_is_load(id_is_load), .id_halt(id_halt), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .stall_if(u0_stall_if), .stall_id(u0_stall_id),
        .flush_if(u0_flush_if), .freeze(u0_freeze), .fwd_a_sel(u0_fwd_a_sel),
        .fwd_b_sel(u0_fwd_b_sel), .halt(u0_halt), .busy(u0_busy)
    );

    pipeline_hazard_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .FWD_EN(0)) u1 (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_wsel(id_wsel),
        .id_is_load(id_is_load), .id_halt(id_halt), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .stall_if(u1_stall_if), .stall_id(u1_stall_id),
        .flush_if(u1_flush_if), .freeze(u1_freeze), .fwd_a_sel(u1_fwd_a_sel),
        .fwd_b_sel(u1_fwd_b_sel), .halt(u1_halt), .busy(u1_busy)
    );

    function automatic stim_t op(int ws, int rs, int rt, bit urs, bit urt, bit wen, bit ld);
        stim_t s;
        s.rst = 1'b0; s.v = 1'b1;
        s.rs = REG_W'(rs); s.rt = REG_W'(rt); s.ws = REG_W'(ws);
        s.urs = urs; s.urt = urt; s.wen = wen; s.ld = ld;
        s.hl = 1'b0; s.br = 1'b0; s.mw = 1'b0;
        return s;
    endfunction

    function automatic stim_t alu(int ws, int rs, int rt);
        return op(ws, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic stim_t lw(int ws, int rs);
        return op(ws, rs, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = op(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        s.v = 1'b0;
        return s;
    endfunction

    function automatic stim_t with_br(stim_t s);
        stim_t r = s;
        r.br = 1'b1;
        return r;
    endfunction

    function automatic stim_t with_mw(stim_t s);
        stim_t r = s;
        r.mw = 1'b1;
        return r;
    endfunction

    function automatic stim_t with_hl(stim_t s);
        stim_t r = s;
        r.hl = 1'b1;
        return r;
    endfunction

    function automatic stim_t with_rst(stim_t s);
        stim_t r = s;
        r.rst = 1'b1;
        return r;
    endfunction

    // Expected output bundle: stall_if, stall_id, flush_if, freeze, fwd_a, fwd_b, halt, busy.
    function automatic logic [OW-1:0] ev(bit sif, bit sid, bit fif, bit frz, int fa, int fb,
                                         bit hlt, bit bsy);
        return {sif, sid, fif, frz, FW'(fa), FW'(fb), hlt, bsy};
    endfunction

    function automatic logic [OW-1:0] obs(int d);
        if (d == 0) begin
            return {u0_stall_if, u0_stall_id, u0_flush_if, u0_freeze,
                    u0_fwd_a_sel, u0_fwd_b_sel, u0_halt, u0_busy};
        end
        return {u1_stall_if, u1_stall_id, u1_flush_if, u1_freeze,
                u1_fwd_a_sel, u1_fwd_b_sel, u1_halt, u1_busy};
    endfunction

    task automatic apply(input stim_t s);
        RST = s.rst; id_valid = s.v; id_rs = s.rs; id_rt = s.rt;
        id_uses_rs = s.urs; id_uses_rt = s.urt; id_wen = s.wen; id_wsel = s.ws;
        id_is_load = s.ld; id_halt = s.hl; branch_taken = s.br; mem_wait = s.mw;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        apply(with_rst(nop()));
        @(posedge CLK);
        @(posedge CLK);
    endtask

    task automatic test_reset();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        @(negedge CLK);
        apply(alu(5, 0, 0));
        do_reset();
        st.push_back(alu(6, 5, 5));           ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(with_br(alu(7, 6, 0)));  ex.push_back(ev(0, 0, 1, 0, 1, 0, 0, 1));
        st.push_back(with_mw(nop()));         ex.push_back(ev(1, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            exp_q.push_back('{tag: $sformatf("reset[%0d]", i), v: ex[i]});
            #1;
            got  = obs(0);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", want.tag, got, want.v);
            end
        end
    endtask

    task automatic test_forward();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        do_reset();
        st.push_back(alu(8, 1, 2));    ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(alu(10, 8, 3));   ex.push_back(ev(0, 0, 0, 0, 1, 0, 0, 1));
        st.push_back(nop());           ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(alu(11, 8, 10));  ex.push_back(ev(0, 0, 0, 0, 3, 2, 0, 1));
        st.push_back(alu(8, 11, 0));   ex.push_back(ev(0, 0, 0, 0, 1, 0, 0, 1));
        st.push_back(nop());           ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(alu(12, 8, 11));  ex.push_back(ev(0, 0, 0, 0, 2, 3, 0, 1));
        st.push_back(alu(12, 12, 8));  ex.push_back(ev(0, 0, 0, 0, 1, 3, 0, 1));
        st.push_back(alu(1, 12, 12));  ex.push_back(ev(0, 0, 0, 0, 1, 1, 0, 1));
        st.push_back(op(0, 1, 12, 1'b0, 1'b1, 1'b0, 1'b0));
        ex.push_back(ev(0, 0, 0, 0, 0, 2, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            exp_q.push_back('{tag: $sformatf("forward[%0d]", i), v: ex[i]});
            #1;
            got  = obs(0);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", want.tag, got, want.v);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        do_reset();
        st.push_back(lw(9, 2));               ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(alu(3, 1, 9));           ex.push_back(ev(1, 1, 0, 0, 0, 1, 0, 1));
        st.push_back(alu(3, 1, 9));           ex.push_back(ev(0, 0, 0, 0, 0, 2, 0, 1));
        st.push_back(lw(7, 3));               ex.push_back(ev(0, 0, 0, 0, 1, 0, 0, 1));
        st.push_back(with_br(alu(4, 7, 0)));  ex.push_back(ev(0, 0, 1, 0, 1, 0, 0, 1));
        st.push_back(nop());                  ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(nop());                  ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(nop());                  ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            exp_q.push_back('{tag: $sformatf("load_use[%0d]", i), v: ex[i]});
            #1;
            got  = obs(0);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", want.tag, got, want.v);
            end
        end
    endtask

    task automatic test_r0();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        do_reset();
        st.push_back(lw(0, 0));      ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(alu(2, 0, 0));  ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            for (int d = 0; d < 2; d++) begin
                exp_q.push_back('{tag: $sformatf("r0_u%0d[%0d]", d, i), v: ex[i]});
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                got  = obs(d);
                want = exp_q.pop_front();
                n_cmp++;
                if (got !== want.v) begin
                    n_bad++;
                    $display("FAIL %s: got %b want %b", want.tag, got, want.v);
                end
            end
        end
    endtask

    task automatic test_stall_only();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        do_reset();
        st.push_back(alu(4, 1, 2));  ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(alu(5, 4, 3));  ex.push_back(ev(1, 1, 0, 0, 0, 0, 0, 1));
        st.push_back(alu(5, 4, 3));  ex.push_back(ev(1, 1, 0, 0, 0, 0, 0, 1));
        st.push_back(alu(5, 4, 3));  ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(nop());         ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            exp_q.push_back('{tag: $sformatf("stall_only[%0d]", i), v: ex[i]});
            #1;
            got  = obs(1);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", want.tag, got, want.v);
            end
        end
    endtask

    task automatic test_freeze();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        do_reset();
        st.push_back(alu(8, 0, 0));           ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            st.push_back(with_mw(alu(6, 8, 0)));
            ex.push_back(ev(1, 0, 0, 1, 1, 0, 0, 1));
        end
        st.push_back(alu(6, 8, 0));           ex.push_back(ev(0, 0, 0, 0, 1, 0, 0, 1));
        st.push_back(alu(1, 8, 6));           ex.push_back(ev(0, 0, 0, 0, 2, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            exp_q.push_back('{tag: $sformatf("freeze[%0d]", i), v: ex[i]});
            #1;
            got  = obs(0);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", want.tag, got, want.v);
            end
        end
    endtask

    task automatic test_halt();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        exp_t want;
        do_reset();
        st.push_back(alu(3, 0, 0));
        ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(with_br(with_hl(op(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0))));
        ex.push_back(ev(0, 0, 1, 0, 0, 0, 0, 1));
        st.push_back(nop());
        ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        st.push_back(with_hl(op(3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0)));
        ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        for (int c = 0; c < 3; c++) begin
            st.push_back(op(2, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0));
            ex.push_back(ev(1, 0, 1, 0, 0, 0, 0, 1));
        end
        st.push_back(op(2, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0));
        ex.push_back(ev(1, 0, 1, 0, 0, 0, 0, 0));
        st.push_back(nop());
        ex.push_back(ev(1, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(alu(4, 0, 0));
        ex.push_back(ev(1, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(with_rst(nop()));
        ex.push_back(ev(1, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(nop());
        ex.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge CLK);
            apply(st[i]);
            exp_q.push_back('{tag: $sformatf("halt[%0d]", i), v: ex[i]});
            #1;
            got  = obs(0);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", want.tag, got, want.v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1);
    end

    initial begin
        apply(with_rst(nop()));
        test_reset();
        test_forward();
        test_load_use();
        test_r0();
        test_stall_only();
        test_freeze();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
